// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between the CPU and a debug/loader port.
// Access takes LAT+2 cycles (sample, LAT strobe cycles, ack); requesters stall until their ack pulse.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          we_q;
  logic          any_req;
  logic          grant_dbg;

  assign any_req = cpu_req | dbg_req;

  // Debug wins when alone, or when the CPU has used up its bounded priority.
  assign grant_dbg = dbg_req & (~cpu_req | (starve_cnt == SW'(STARVE_MAX)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (lat_cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt    <= '0;
      starve_cnt <= '0;
      we_q       <= 1'b0;
      owner      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A CPU win with debug waiting is the only way to grow the counter.
          if (!dbg_req || grant_dbg) begin
            starve_cnt <= '0;
          end else if (starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
          if (any_req) begin
            owner     <= grant_dbg;
            we_q      <= grant_dbg ? dbg_we    : cpu_we;
            mem_addr  <= grant_dbg ? dbg_addr  : cpu_addr;
            mem_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
            lat_cnt   <= CW'(LAT - 1);
          end
        end
        BUSY: begin
          if (lat_cnt == '0) begin
            if (!we_q) begin
              if (owner) dbg_rdata <= mem_rdata;
              else       cpu_rdata <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes and acks decode straight from state so reset kills them immediately.
  assign mem_rd  = (state == BUSY) & ~we_q;
  assign mem_wr  = (state == BUSY) &  we_q;
  assign cpu_ack = (state == DONE) & ~owner;
  assign dbg_ack = (state == DONE) &  owner;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses LAT=2/STARVE_MAX=4, instance 1 LAT=1/STARVE_MAX=1.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Per instance i, per port p (0 = CPU, 1 = debug).
  logic [1:0]  req [2];
  logic [1:0]  we  [2];
  logic [1:0]  ack [2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic [31:0] rdata [2][2];
  logic [31:0] m_addr [2], m_wdata [2], m_rdata [2];
  logic        m_rd [2], m_wr [2], owner [2], busy [2];

  logic [31:0] dev_mem [2][256];

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(2), .STARVE_MAX(4)) u_dut0 (
    .clk(clk), .rst(rst),
    .cpu_req(req[0][0]), .cpu_we(we[0][0]), .cpu_addr(addr[0][0]), .cpu_wdata(wdata[0][0]),
    .cpu_rdata(rdata[0][0]), .cpu_ack(ack[0][0]),
    .dbg_req(req[0][1]), .dbg_we(we[0][1]), .dbg_addr(addr[0][1]), .dbg_wdata(wdata[0][1]),
    .dbg_rdata(rdata[0][1]), .dbg_ack(ack[0][1]),
    .mem_addr(m_addr[0]), .mem_wdata(m_wdata[0]), .mem_rd(m_rd[0]), .mem_wr(m_wr[0]),
    .mem_rdata(m_rdata[0]), .owner(owner[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(1), .STARVE_MAX(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(req[1][0]), .cpu_we(we[1][0]), .cpu_addr(addr[1][0]), .cpu_wdata(wdata[1][0]),
    .cpu_rdata(rdata[1][0]), .cpu_ack(ack[1][0]),
    .dbg_req(req[1][1]), .dbg_we(we[1][1]), .dbg_addr(addr[1][1]), .dbg_wdata(wdata[1][1]),
    .dbg_rdata(rdata[1][1]), .dbg_ack(ack[1][1]),
    .mem_addr(m_addr[1]), .mem_wdata(m_wdata[1]), .mem_rd(m_rd[1]), .mem_wr(m_wr[1]),
    .mem_rdata(m_rdata[1]), .owner(owner[1]), .busy(busy[1])
  );

  // Memory device: combinational read data while strobed, write on strobed edges.
  assign m_rdata[0] = m_rd[0] ? dev_mem[0][m_addr[0][9:2]] : 32'h0;
  assign m_rdata[1] = m_rd[1] ? dev_mem[1][m_addr[1][9:2]] : 32'h0;
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (m_wr[i]) dev_mem[i][m_addr[i][9:2]] = m_wdata[i];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a countdown of remaining cycles per access,
  // winner chosen by the arbitration rules, memory image kept separately.
  int          latv [2] = '{2, 1};
  int          smx  [2] = '{4, 1};
  int          tmr  [2] = '{0, 0};
  int          starve [2] = '{0, 0};
  int          w;
  logic        mown [2];
  logic        mwe  [2];
  logic [31:0] maddr [2], mwd [2];
  logic [31:0] exp_rd [2][2];
  logic [31:0] ref_mem [2][256];
  logic [1:0]  last_ack [2];
  bit          chk_en = 1'b1;

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        tmr[i] = 0; starve[i] = 0; mown[i] = 1'b0;
        exp_rd[i][0] = 32'h0; exp_rd[i][1] = 32'h0;
      end else if (tmr[i] > 0) begin
        if (tmr[i] == latv[i] + 1 && mwe[i]) ref_mem[i][maddr[i][9:2]] = mwd[i];
        tmr[i]--;
        if (tmr[i] == 1 && !mwe[i]) exp_rd[i][mown[i]] = ref_mem[i][maddr[i][9:2]];
      end else if (req[i] != 2'b00) begin
        if (req[i] == 2'b11) w = (starve[i] == smx[i]) ? 1 : 0;
        else                 w = req[i][1] ? 1 : 0;
        if (!req[i][1] || w == 1) starve[i] = 0;
        else if (starve[i] < smx[i]) starve[i]++;
        mown[i]  = (w == 1);
        mwe[i]   = we[i][w];
        maddr[i] = addr[i][w];
        mwd[i]   = wdata[i][w];
        tmr[i]   = latv[i] + 1;
      end else begin
        starve[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      last_ack[i] = ack[i];
      if (chk_en) begin
        chk1($sformatf("ref%0d busy", i), busy[i], tmr[i] > 0);
        chk1($sformatf("ref%0d mem_rd", i), m_rd[i], tmr[i] > 1 && !mwe[i]);
        chk1($sformatf("ref%0d mem_wr", i), m_wr[i], tmr[i] > 1 && mwe[i]);
        chk1($sformatf("ref%0d cpu_ack", i), ack[i][0], tmr[i] == 1 && !mown[i]);
        chk1($sformatf("ref%0d dbg_ack", i), ack[i][1], tmr[i] == 1 && mown[i]);
        chk1($sformatf("ref%0d owner", i), owner[i], mown[i]);
        if (tmr[i] > 1) chk32($sformatf("ref%0d mem_addr", i), m_addr[i], maddr[i]);
        if (tmr[i] > 1 && mwe[i]) chk32($sformatf("ref%0d mem_wdata", i), m_wdata[i], mwd[i]);
        chk32($sformatf("ref%0d cpu_rdata", i), rdata[i][0], exp_rd[i][0]);
        chk32($sformatf("ref%0d dbg_rdata", i), rdata[i][1], exp_rd[i][1]);
      end
    end
  end

  typedef struct {
    logic        creq, cwe;
    logic [31:0] caddr, cwd;
    logic        dreq, dwe;
    logic [31:0] daddr, dwd;
    logic        e_rd, e_wr, e_cack, e_dack, e_own, e_busy, e_chka;
    logic [31:0] e_addr, e_wd, e_crd, e_drd;
  } vec_t;

  vec_t tbl [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int i, input int p);
    req[i][p]   = 1'b1;
    we[i][p]    = 1'($urandom_range(0, 1));
    addr[i][p]  = 32'($urandom_range(0, 255)) << 2;
    wdata[i][p] = $urandom;
  endtask

  int cq0 [$], cq1 [$], wq0 [$], wq1 [$];
  int got;

  initial begin
    localparam logic [31:0] A = 32'h40, B = 32'h100, D = 32'hDEADBEEF, R = 32'h12345678, Z = 32'h0;

    for (int i = 0; i < 2; i++) begin
      req[i] = 2'b00; we[i] = 2'b00;
      for (int p = 0; p < 2; p++) begin addr[i][p] = 32'h0; wdata[i][p] = 32'h0; end
      for (int k = 0; k < 256; k++) begin
        dev_mem[i][k] = 32'hC0DE0000 + 32'(k);
        ref_mem[i][k] = 32'hC0DE0000 + 32'(k);
      end
      dev_mem[i][16] = R;
      ref_mem[i][16] = R;
    end

    //            creq  cwe   caddr cwd dreq  dwe   daddr dwd | rd    wr    cack  dack  own   busy  chka  addr wd crd drd
    tbl[0] = '{1'b1, 1'b0, A, Z, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z, Z, Z};
    tbl[1] = '{1'b1, 1'b0, A, Z, 1'b0, 1'b0, Z, Z, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, A, Z, Z, Z};
    tbl[2] = '{1'b1, 1'b0, A, Z, 1'b0, 1'b0, Z, Z, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, A, Z, Z, Z};
    tbl[3] = '{1'b1, 1'b0, A, Z, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, Z, Z, R, Z};
    tbl[4] = '{1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z, R, Z};
    tbl[5] = '{1'b0, 1'b0, Z, Z, 1'b1, 1'b1, B, D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z, R, Z};
    tbl[6] = '{1'b0, 1'b0, Z, Z, 1'b1, 1'b1, B, D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, B, D, R, Z};
    tbl[7] = '{1'b0, 1'b0, Z, Z, 1'b1, 1'b1, B, D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, B, D, R, Z};
    tbl[8] = '{1'b0, 1'b0, Z, Z, 1'b1, 1'b1, B, D, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, Z, Z, R, Z};
    tbl[9] = '{1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Z, Z, R, Z};

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk1("rst mem_rd", m_rd[i], 1'b0);
      chk1("rst mem_wr", m_wr[i], 1'b0);
      chk32("rst mem_addr", m_addr[i], 32'h0);
      chk32("rst mem_wdata", m_wdata[i], 32'h0);
      chk32("rst cpu_rdata", rdata[i][0], 32'h0);
      chk32("rst dbg_rdata", rdata[i][1], 32'h0);
      chk1("rst cpu_ack", ack[i][0], 1'b0);
      chk1("rst dbg_ack", ack[i][1], 1'b0);
      chk1("rst owner", owner[i], 1'b0);
      chk1("rst busy", busy[i], 1'b0);
    end
    tick();
    rst = 1'b0;

    // Single CPU read then single debug write, cycle by cycle on instance 0.
    for (int k = 0; k < 10; k++) begin
      req[0][0] = tbl[k].creq; we[0][0] = tbl[k].cwe; addr[0][0] = tbl[k].caddr; wdata[0][0] = tbl[k].cwd;
      req[0][1] = tbl[k].dreq; we[0][1] = tbl[k].dwe; addr[0][1] = tbl[k].daddr; wdata[0][1] = tbl[k].dwd;
      @(negedge clk);
      chk1($sformatf("vec%0d mem_rd", k), m_rd[0], tbl[k].e_rd);
      chk1($sformatf("vec%0d mem_wr", k), m_wr[0], tbl[k].e_wr);
      chk1($sformatf("vec%0d cpu_ack", k), ack[0][0], tbl[k].e_cack);
      chk1($sformatf("vec%0d dbg_ack", k), ack[0][1], tbl[k].e_dack);
      chk1($sformatf("vec%0d owner", k), owner[0], tbl[k].e_own);
      chk1($sformatf("vec%0d busy", k), busy[0], tbl[k].e_busy);
      chk32($sformatf("vec%0d cpu_rdata", k), rdata[0][0], tbl[k].e_crd);
      chk32($sformatf("vec%0d dbg_rdata", k), rdata[0][1], tbl[k].e_drd);
      if (tbl[k].e_chka) chk32($sformatf("vec%0d mem_addr", k), m_addr[0], tbl[k].e_addr);
      if (tbl[k].e_chka && tbl[k].e_wr) chk32($sformatf("vec%0d mem_wdata", k), m_wdata[0], tbl[k].e_wd);
      tick();
    end

    // Both ports held on both instances: bounded priority and strict alternation.
    for (int i = 0; i < 2; i++) begin
      req[i] = 2'b11; we[i] = 2'b00;
      addr[i][0] = 32'h8; addr[i][1] = 32'hC;
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ack[0] != 2'b00) begin cq0.push_back(c); wq0.push_back(ack[0][1] ? 1 : 0); end
      if (ack[1] != 2'b00) begin cq1.push_back(c); wq1.push_back(ack[1][1] ? 1 : 0); end
      tick();
    end
    chk32("starve4 ack count", 32'(cq0.size()), 32'd7);
    for (int k = 0; k < 6 && k < cq0.size(); k++) begin
      chk32($sformatf("starve4 ack%0d cycle", k), 32'(cq0[k]), 32'(3 + 4 * k));
      chk32($sformatf("starve4 ack%0d winner", k), 32'(wq0[k]), (k == 4) ? 32'd1 : 32'd0);
    end
    chk32("starve1 ack count", 32'(cq1.size()), 32'd10);
    for (int k = 0; k < 4 && k < cq1.size(); k++) begin
      chk32($sformatf("starve1 ack%0d cycle", k), 32'(cq1[k]), 32'(2 + 3 * k));
      chk32($sformatf("starve1 ack%0d winner", k), 32'(wq1[k]), 32'(k % 2));
    end
    req[0] = 2'b00; req[1] = 2'b00;
    repeat (6) tick();

    // Reset in the middle of a CPU read, then a clean re-issue.
    req[0] = 2'b01; we[0] = 2'b00; addr[0][0] = 32'h40;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk1("midrst strobe before", m_rd[0], 1'b1);
    #1 rst = 1'b1;
    req[0] = 2'b00;
    #1;
    chk1("midrst mem_rd", m_rd[0], 1'b0);
    chk1("midrst busy", busy[0], 1'b0);
    chk1("midrst cpu_ack", ack[0][0], 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    req[0] = 2'b01;
    got = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ack[0][0] && got < 0) got = n;
      tick();
      if (got == n) req[0] = 2'b00;
    end
    chk32("reissue latency", 32'(got), 32'd3);
    chk32("reissue cpu_rdata", rdata[0][0], R);

    // LAT=1 back-to-back CPU reads of 0x0 then 0x4 on instance 1.
    req[1] = 2'b01; we[1] = 2'b00; addr[1][0] = 32'h0;
    cq1.delete();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (ack[1][0]) begin
        cq1.push_back(c);
        chk32($sformatf("b2b rdata c%0d", c), rdata[1][0], (c < 4) ? 32'hC0DE0000 : 32'hC0DE0001);
      end
      tick();
      if (c + 1 == 3) addr[1][0] = 32'h4;
      if (c + 1 == 6) req[1] = 2'b00;
    end
    chk32("b2b ack count", 32'(cq1.size()), 32'd2);
    if (cq1.size() == 2) begin
      chk32("b2b ack0 cycle", 32'(cq1[0]), 32'd2);
      chk32("b2b ack1 cycle", 32'(cq1[1]), 32'd5);
    end

    // Randomized traffic with occasional resets, checked by the reference model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        req[0] = 2'b00; req[1] = 2'b00;
      end else begin
        for (int i = 0; i < 2; i++) begin
          for (int p = 0; p < 2; p++) begin
            if (req[i][p]) begin
              if (last_ack[i][p]) begin
                if ($urandom_range(0, 1) == 0) req[i][p] = 1'b0;
                else new_req(i, p);
              end
            end else if ($urandom_range(0, 2) == 0) begin
              new_req(i, p);
            end
          end
        end
      end
    end
    rst = 1'b0;
    req[0] = 2'b00; req[1] = 2'b00;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single unified instruction/data memory of the multi-cycle CPU between two requesters.
- Requester 0 is the CPU memory interface (MemRd/MemWr and the IorD-selected address). Requester 1 is a debug/program-loader port.
- Drives a fixed-latency memory, stalls each requester through a req/ack handshake, and prevents loader starvation with a bounded-priority counter.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- LAT, 2, memory access latency in cycles (>=1); mem_rdata is valid in the last cycle of the access.
- STARVE_MAX, 4, consecutive CPU grants allowed while the debug request is pending (>=1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data (registered).
- cpu_ack  out  1  one-cycle completion pulse.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack: same as the cpu_* ports, for the debug port.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_rdata  in  DW  memory read data.
- owner  out  1  current or last grant (0 = CPU, 1 = debug).
- busy  out  1  high while an access is in BUSY or DONE.

Behaviour:
- Reset (async, immediate): state IDLE; mem_rd = mem_wr = 0; mem_addr, mem_wdata, cpu_rdata and dbg_rdata = 0; both acks = 0; owner = 0; starve counter = 0; busy = 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: requests are sampled only here. With no request, stay in IDLE.
  - IDLE with a request: pick the winner, latch its addr/we/wdata into the mem_* registers, set owner, load the latency counter with LAT-1, go to BUSY.
  - BUSY: mem_rd = ~we_latched and mem_wr = we_latched, held for exactly LAT cycles. mem_addr and mem_wdata stay stable throughout.
  - BUSY exit: when the counter reaches 0, go to DONE. On that same edge, for a read, capture mem_rdata into the winner's rdata register.
  - DONE: strobes low; the winner's ack = 1 for this one cycle only; next state is IDLE.
- Latency: req high at IDLE edge k -> strobes active in cycles k+1..k+LAT -> ack in cycle k+LAT+1. An access occupies the memory for LAT+2 cycles, including the IDLE sampling cycle.
- Handshake:
  - A requester holds req and its addr/we/wdata stable until it sees ack.
  - A requester drops req, or presents a new request, on the edge that ends the ack cycle.
  - Requests are not sampled during DONE, so a stale req is never double-granted.
- rdata: updated only on a completed read for that port. It holds its value across writes and across the other port's accesses.
- Arbitration in IDLE:
  - CPU only -> CPU. Debug only -> debug.
  - Both requesting: the CPU wins unless starve counter == STARVE_MAX, in which case debug wins.
- Starve counter:
  - Increments on each CPU grant made while dbg_req = 1.
  - Clears on any debug grant, and in any IDLE cycle with dbg_req = 0.
  - Saturates at STARVE_MAX.
- Write access: mem_rdata is ignored and both rdata registers are unchanged.
- Reset mid-access: the strobes drop in the same cycle and no ack is issued. Requesters must re-issue after reset.
- owner is held after DONE until the next grant.

Test Plan:
- Single CPU read, LAT=2, memory returns 0x1234_5678 at 0x40: cpu_req at cycle 0 -> mem_rd high in cycles 1-2 with mem_addr=0x40 -> cpu_ack in cycle 3 and cpu_rdata = 0x12345678; dbg_ack stays 0.
- Debug write 0xDEADBEEF to 0x100 -> mem_wr high in cycles 1-2, mem_wdata = 0xDEADBEEF, dbg_ack in cycle 3; cpu_rdata and dbg_rdata unchanged.
- Both requests asserted continuously, STARVE_MAX=4 -> grant order CPU, CPU, CPU, CPU, DBG, CPU... with owner toggling accordingly; ack pulses exactly 4 cycles apart.
- STARVE_MAX=1 with both requests held -> strict alternation CPU, DBG, CPU, DBG.
- rst pulsed high in the middle of BUSY during a CPU read -> mem_rd drops immediately, no cpu_ack, state IDLE. A re-issued request completes normally with LAT+1 cycles from req to ack.
- LAT=1 back-to-back CPU reads of 0x0 then 0x4 -> acks in cycles 2 and 5; cpu_rdata updates at each ack; the stale req during the ack cycle is not granted twice.
